layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Parametrised, pipelined successor to the fixed 3-layer RGB OR-combiner in the VGA game path.
//  Merges NUM_LAYERS sprite/background layers into one RGB pixel, using either OR blend or priority mode.
//  Forces black during blanking.
//  Detects per-frame overlaps between foreground layers (e.g. character vs coin) for game logic.
//  Sits between the layer generators and the VGA output buffer.
// PARAMETERS
//  NUM_LAYERS  3  layer count, 2..8; layer 0 = background, higher index = higher priority
//  COLOR_W     1  bits per colour channel (1 = legacy 1-bit RGB)
//  CNT_W       8  width of the per-frame collision pixel counter
// PORTS
//  clk            in   1                     system clock, all logic rising-edge
//  rst            in   1                     synchronous, active-high reset
//  pix_valid      in   1                     input pixel qualifier
//  blank          in   1                     1 = blanking interval; output black
//  frame_start    in   1                     1-cycle pulse, coincident with first pixel of frame
//  mode_priority  in   1                     0 = OR blend of all enabled layers, 1 = top-opaque-layer wins
//  layer_en       in   NUM_LAYERS            per-layer enable; disabled layer is treated as transparent
//  layer_opaque   in   NUM_LAYERS            per-layer coverage of the current pixel
//  layer_rgb      in   NUM_LAYERS*3*COLOR_W  layer i at [i*3*COLOR_W +: 3*COLOR_W], packed {r,g,b}
//  r_out,g_out,b_out out COLOR_W             composited colour, registered
//  out_valid      out  1                     pix_valid delayed by 2
//  coll_pulse     out  1                     1 on the output cycle of a colliding pixel
//  coll_frame     out  1                     sticky: a collision occurred in the current frame
//  coll_count_last out CNT_W                 colliding-pixel count of the previous frame
// BEHAVIOUR
//  - Latency: fixed 2 cycles from inputs to all outputs; no stalls, no backpressure.
//    - S1 registers the inputs.
//    - S2 computes the result and registers the outputs.
//  - Reset: all pipeline registers, outputs, counter and sticky flag go to 0. Pipeline bubbles to 0.
//  - Effective coverage: eff[i] = layer_en[i] & layer_opaque[i].
//  - OR mode: each channel = bitwise OR of layer_rgb[i] over all i with eff[i].
//    - With COLOR_W=1 and all eff, this reproduces the legacy block.
//  - Priority mode: colour of the highest i with eff[i]; if no eff bit is set, output 0.
//  - Blanking: if blank or !pix_valid (S1-registered), output colour = 0 and coll_pulse = 0.
//  - Collision: a valid, unblanked pixel where count of eff[i] for i>=1 is >= 2.
//    - Layer 0 never collides.
//    - Collision is evaluated in both modes.
//  - Counter:
//    - Increments by 1 per colliding pixel.
//    - Saturates at 2^CNT_W-1; it does not wrap.
//  - Frame boundary (S1-registered frame_start), on the S2 edge:
//    - coll_count_last <= running count, excluding this pixel.
//    - Count <= this pixel's collision (0 or 1).
//    - coll_frame <= this pixel's collision.
//    - The pixel arriving with frame_start therefore belongs to the new frame.
//  - frame_start with pix_valid=0: the boundary action still occurs; the pixel contributes 0.
//  - Back-to-back frame_start pulses: each one latches; an empty frame yields coll_count_last = 0.
//  - mode_priority and layer_en are sampled per pixel in S1. Changes mid-frame take effect
//    exactly 2 cycles later at the output, with no glitch.
//  - rst asserted mid-frame: flush everything; coll_count_last = 0 until the next frame_start.
// STRUCTURE
//  - Shared include, layer_defs.vh:
//    - MODE_OR = 1'b0, MODE_PRIO = 1'b1.
//    - RGB pack/unpack index macros.
//  - Sub-module layer_priority_mux (combinational, parametrised NUM_LAYERS/COLOR_W):
//    - Inputs: eff vector and packed rgb.
//    - Outputs: OR-blend rgb, priority rgb, collision flag.
//  - Top level holds the S1/S2 registers, counter, sticky flag and frame latch.
// TESTING
//  - Test 1, legacy equivalence:
//    - Setup: COLOR_W=1, OR mode, all enabled.
//    - Stimulus: sweep all 2^9 rgb/opaque=1 combos.
//    - Check: out = OR of layers, 2 cycles later.
//  - Test 2, priority:
//    - Layer rgb: L0=3'b001, L1=3'b010, L2=3'b100.
//    - All opaque -> 100. L2 transparent -> 010. Only L0 opaque -> 001. None opaque -> 000.
//  - Test 3, enable and blank:
//    - layer_en=3'b011 with L2 opaque -> L2 ignored.
//    - blank=1 -> out 0 and coll_pulse 0, even while colliding.
//  - Test 4, collision count:
//    - L1 and L2 overlap on 5 valid pixels; then frame_start.
//    - Check: coll_count_last = 5 and coll_frame clears.
//    - Overlap of L0 and L1 only -> no pulse.
//  - Test 5, saturation and boundary:
//    - Setup: CNT_W=4.
//    - Stimulus: 20 colliding pixels, then frame_start on a colliding pixel.
//    - Check: coll_count_last = 15; new count = 1; coll_frame = 1.
//  - Test 6, reset mid-stream:
//    - Assert rst for 1 cycle during a colliding run.
//    - Check: all outputs 0 the next cycle; out_valid stays 0 for 2 cycles after release.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// layer_compositor_pkg
// Shared definitions for the layer compositor slice:
//   - blend mode encoding carried on mode_priority
//   - channel positions inside a packed {r,g,b} pixel
//   - helper that locates a layer inside the flat layer_rgb bus
// No ports; imported by layer_compositor and layer_priority_mux.
// -----------------------------------------------------------------------------
package layer_compositor_pkg;

    // Encoding of the mode_priority input
    typedef enum logic {
        MODE_OR   = 1'b0,
        MODE_PRIO = 1'b1
    } blend_mode_e;

    // Number of colour channels in one pixel
    localparam int RGB_CH = 3;

    // Channel slot inside a packed pixel, in units of COLOR_W: {r,g,b}
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    // Lowest bit of layer 'layer' inside the flat layer_rgb bus
    function automatic int rgbLsb(input int layer, input int colorW);
        return layer * RGB_CH * colorW;
    endfunction

endpackage

// File: rtl/layer_compositor_priority_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// layer_priority_mux
// Combinational core of the compositor. From the effective coverage vector
// and the packed layer colours it produces both candidate colours and the
// foreground collision flag; the top level chooses between the colours.
// Ports:
//   i_eff      [NUM_LAYERS]            layer_en & layer_opaque, per layer
//   i_rgb      [NUM_LAYERS*3*COLOR_W]  layer i at rgbLsb(i) +: 3*COLOR_W
//   o_orRgb    [3*COLOR_W]             OR of every covering layer
//   o_prioRgb  [3*COLOR_W]             colour of highest covering layer, 0 if none
//   o_collide  [1]                     two or more covering layers with index >= 1
// -----------------------------------------------------------------------------
module layer_priority_mux
    import layer_compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int COLOR_W    = 1
)
(
    input  logic [NUM_LAYERS-1:0]                 i_eff,
    input  logic [NUM_LAYERS*RGB_CH*COLOR_W-1:0]  i_rgb,
    output logic [RGB_CH*COLOR_W-1:0]             o_orRgb,
    output logic [RGB_CH*COLOR_W-1:0]             o_prioRgb,
    output logic                                  o_collide
);

    localparam int PIX_W = RGB_CH * COLOR_W;

    logic [PIX_W-1:0] w_orRgb;
    logic [PIX_W-1:0] w_prioRgb;
    logic             w_seenFg;
    logic             w_collide;

    // Walk the layers from background upwards. Later (higher) covering
    // layers overwrite the priority colour, so the top one wins. A collision
    // is the second covering foreground layer; layer 0 is never counted.
    always_comb begin
        w_orRgb   = '0;
        w_prioRgb = '0;
        w_seenFg  = 1'b0;
        w_collide = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (i_eff[i]) begin
                w_orRgb   = w_orRgb | i_rgb[rgbLsb(i, COLOR_W) +: PIX_W];
                w_prioRgb = i_rgb[rgbLsb(i, COLOR_W) +: PIX_W];
                if (i >= 1) begin
                    if (w_seenFg) begin
                        w_collide = 1'b1;
                    end
                    w_seenFg = 1'b1;
                end
            end
        end
    end

    assign o_orRgb   = w_orRgb;
    assign o_prioRgb = w_prioRgb;
    assign o_collide = w_collide;

endmodule

// File: rtl/layer_compositor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// layer_compositor
// Two-stage pipelined compositor between the layer generators and the VGA
// output buffer. Stage 1 registers the inputs, stage 2 registers the
// composited pixel and the collision bookkeeping; every output appears
// exactly two cycles after its input pixel.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pix_valid, blank         pixel qualifier, blanking (forces black)
//   frame_start              pulse on the first pixel of a frame
//   mode_priority            0 = OR blend, 1 = top covering layer wins
//   layer_en, layer_opaque   per-layer enable and coverage
//   layer_rgb                packed {r,g,b} per layer, layer 0 lowest
//   r_out, g_out, b_out      composited colour
//   out_valid                pix_valid delayed by two cycles
//   coll_pulse               colliding pixel marker, aligned with the colour
//   coll_frame               sticky collision flag for the current frame
//   coll_count_last          colliding-pixel count of the previous frame
// -----------------------------------------------------------------------------
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int COLOR_W    = 1,
    parameter int CNT_W      = 8
)
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pix_valid,
    input  logic                                  blank,
    input  logic                                  frame_start,
    input  logic                                  mode_priority,
    input  logic [NUM_LAYERS-1:0]                 layer_en,
    input  logic [NUM_LAYERS-1:0]                 layer_opaque,
    input  logic [NUM_LAYERS*RGB_CH*COLOR_W-1:0]  layer_rgb,
    output logic [COLOR_W-1:0]                    r_out,
    output logic [COLOR_W-1:0]                    g_out,
    output logic [COLOR_W-1:0]                    b_out,
    output logic                                  out_valid,
    output logic                                  coll_pulse,
    output logic                                  coll_frame,
    output logic [CNT_W-1:0]                      coll_count_last
);

    localparam int             PIX_W   = RGB_CH * COLOR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1 registers
    logic                                  r_pixValid;
    logic                                  r_blank;
    logic                                  r_frameStart;
    blend_mode_e                           r_mode;
    logic [NUM_LAYERS-1:0]                 r_eff;
    logic [NUM_LAYERS*PIX_W-1:0]           r_rgb;

    // Stage 2 registers
    logic [PIX_W-1:0]                      r_pixOut;
    logic                                  r_outValid;
    logic                                  r_collPulse;
    logic                                  r_collFrame;
    logic [CNT_W-1:0]                      r_collCount;
    logic [CNT_W-1:0]                      r_collCountLast;

    // Stage 2 combinational results
    logic [PIX_W-1:0]                      w_orRgb;
    logic [PIX_W-1:0]                      w_prioRgb;
    logic                                  w_collide;
    logic                                  w_active;
    logic                                  w_hit;
    logic [PIX_W-1:0]                      w_pixNext;
    logic [CNT_W-1:0]                      w_countInc;

    // Stage 1: capture the pixel. Enable and coverage are folded into the
    // effective coverage vector here, so mode and enable changes take effect
    // on a per-pixel basis with no partial-update glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixValid   <= 1'b0;
            r_blank      <= 1'b0;
            r_frameStart <= 1'b0;
            r_mode       <= MODE_OR;
            r_eff        <= '0;
            r_rgb        <= '0;
        end else begin
            r_pixValid   <= pix_valid;
            r_blank      <= blank;
            r_frameStart <= frame_start;
            r_mode       <= blend_mode_e'(mode_priority);
            r_eff        <= layer_en & layer_opaque;
            r_rgb        <= layer_rgb;
        end
    end

    layer_priority_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W)
    ) u_mux (
        .i_eff      (r_eff),
        .i_rgb      (r_rgb),
        .o_orRgb    (w_orRgb),
        .o_prioRgb  (w_prioRgb),
        .o_collide  (w_collide)
    );

    // Only a valid pixel outside blanking shows colour or can collide.
    // The counter holds at its maximum rather than wrapping.
    always_comb begin
        w_active   = r_pixValid & ~r_blank;
        w_hit      = w_active & w_collide;
        w_pixNext  = '0;
        if (w_active) begin
            w_pixNext = (r_mode == MODE_PRIO) ? w_prioRgb : w_orRgb;
        end
        w_countInc = (r_collCount == CNT_MAX) ? r_collCount : r_collCount + CNT_W'(1);
    end

    // Stage 2: register the composited pixel and its qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixOut    <= '0;
            r_outValid  <= 1'b0;
            r_collPulse <= 1'b0;
        end else begin
            r_pixOut    <= w_pixNext;
            r_outValid  <= r_pixValid;
            r_collPulse <= w_hit;
        end
    end

    // Per-frame collision bookkeeping. The pixel carrying frame_start opens
    // the new frame: the finished frame's count is published without it, and
    // the new count and sticky flag start from this pixel's own collision.
    // frame_start acts even when the pixel is invalid (w_hit is then 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_collCount     <= '0;
            r_collCountLast <= '0;
            r_collFrame     <= 1'b0;
        end else if (r_frameStart) begin
            r_collCountLast <= r_collCount;
            r_collCount     <= CNT_W'(w_hit);
            r_collFrame     <= w_hit;
        end else if (w_hit) begin
            r_collCount     <= w_countInc;
            r_collFrame     <= 1'b1;
        end
    end

    assign r_out           = r_pixOut[CH_R*COLOR_W +: COLOR_W];
    assign g_out           = r_pixOut[CH_G*COLOR_W +: COLOR_W];
    assign b_out           = r_pixOut[CH_B*COLOR_W +: COLOR_W];
    assign out_valid       = r_outValid;
    assign coll_pulse      = r_collPulse;
    assign coll_frame      = r_collFrame;
    assign coll_count_last = r_collCountLast;

endmodule

// File: tb/tb_layer_compositor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_layer_compositor
// Bench for layer_compositor with 3 layers, 1-bit colour and a 4-bit
// collision counter so that saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_layer_compositor;

   localparam int CNT_MAX = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pixValid = 1'b0;
   logic       blank = 1'b0;
   logic       frameStart = 1'b0;
   logic       modePriority = 1'b0;
   logic [2:0] layerEn = 3'b000;
   logic [2:0] layerOpaque = 3'b000;
   logic [8:0] layerRgb = 9'd0;
   logic       rOut;
   logic       gOut;
   logic       bOut;
   logic       outValid;
   logic       collPulse;
   logic       collFrame;
   logic [3:0] collCountLast;

   // Free-running clock, period 10
   always #5 clk = ~clk;

   layer_compositor #(
      .NUM_LAYERS (3),
      .COLOR_W    (1),
      .CNT_W      (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pix_valid       (pixValid),
      .blank           (blank),
      .frame_start     (frameStart),
      .mode_priority   (modePriority),
      .layer_en        (layerEn),
      .layer_opaque    (layerOpaque),
      .layer_rgb       (layerRgb),
      .r_out           (rOut),
      .g_out           (gOut),
      .b_out           (bOut),
      .out_valid       (outValid),
      .coll_pulse      (collPulse),
      .coll_frame      (collFrame),
      .coll_count_last (collCountLast)
   );

   typedef struct packed {
      logic       valid;
      logic       blank;
      logic       frame;
      logic       mode;
      logic [2:0] en;
      logic [2:0] opaque;
      logic [8:0] rgb;
      logic [2:0] expRgb;
      logic       expPulse;
   } vec_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] rgb;
      logic       pulse;
      logic       frame;
      logic [3:0] last;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   total = 0;
   int   bad = 0;
   int   mCount = 0;
   int   mLast = 0;
   logic mFrame = 1'b0;

   // Layer colours used by the directed vectors: L2=100, L1=010, L0=001
   localparam logic [8:0] RGB3 = 9'b100_010_001;

   function automatic vec_t mk(input logic valid, input logic blk, input logic frame,
                               input logic mode, input logic [2:0] en, input logic [2:0] opaque,
                               input logic [8:0] rgb, input logic [2:0] expRgb, input logic expPulse);
      vec_t v;
      v.valid    = valid;
      v.blank    = blk;
      v.frame    = frame;
      v.mode     = mode;
      v.en       = en;
      v.opaque   = opaque;
      v.rgb      = rgb;
      v.expRgb   = expRgb;
      v.expPulse = expPulse;
      return v;
   endfunction

   // One named comparison
   task automatic checkVal(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Compare current outputs against the oldest scoreboard entry
   task automatic checkOutput();
      exp_t e;
      e = sb.pop_front();
      checkVal("out_valid", int'(outValid), int'(e.valid));
      checkVal("rgb", int'({rOut, gOut, bOut}), int'(e.rgb));
      checkVal("coll_pulse", int'(collPulse), int'(e.pulse));
      checkVal("coll_frame", int'(collFrame), int'(e.frame));
      checkVal("coll_count_last", int'(collCountLast), int'(e.last));
   endtask

   // Drive one pixel, advance the frame-statistics model, queue the result
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      pixValid     = v.valid;
      blank        = v.blank;
      frameStart   = v.frame;
      modePriority = v.mode;
      layerEn      = v.en;
      layerOpaque  = v.opaque;
      layerRgb     = v.rgb;
      if (v.frame) begin
         mLast  = mCount;
         mCount = v.expPulse ? 1 : 0;
         mFrame = v.expPulse;
      end else if (v.expPulse) begin
         if (mCount < CNT_MAX) mCount++;
         mFrame = 1'b1;
      end
      e.valid = v.valid;
      e.rgb   = v.expRgb;
      e.pulse = v.expPulse;
      e.frame = mFrame;
      e.last  = 4'(mLast);
      sb.push_back(e);
   endtask

   // One clock step: results of the pixel driven two steps ago are visible now
   task automatic step(input vec_t v);
      @(negedge clk);
      if (sb.size() >= 2) checkOutput();
      applyStimulus(v);
   endtask

   // Synchronous reset for one edge; relVec is presented as reset releases
   task automatic resetDut(input vec_t relVec);
      exp_t z;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkVal("rst out_valid", int'(outValid), 0);
      checkVal("rst rgb", int'({rOut, gOut, bOut}), 0);
      checkVal("rst coll_pulse", int'(collPulse), 0);
      checkVal("rst coll_frame", int'(collFrame), 0);
      checkVal("rst coll_count_last", int'(collCountLast), 0);
      rst    = 1'b0;
      sb.delete();
      mCount = 0;
      mLast  = 0;
      mFrame = 1'b0;
      z      = '0;
      sb.push_back(z);
      applyStimulus(relVec);
   endtask

   initial begin
      vec_t idle;
      logic [8:0] k9;
      idle = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 9'd0, 3'b000, 1'b0);

      // Priority / enable / blanking / collision-count / saturation vectors
      // Priority mode, all enabled; the first pixel opens a frame
      vecs.push_back(mk(1, 0, 1, 1, 3'b111, 3'b000, RGB3, 3'b000, 0));
      vecs.push_back(mk(1, 0, 0, 1, 3'b111, 3'b111, RGB3, 3'b100, 1));
      vecs.push_back(mk(1, 0, 0, 1, 3'b111, 3'b011, RGB3, 3'b010, 0));
      vecs.push_back(mk(1, 0, 0, 1, 3'b111, 3'b001, RGB3, 3'b001, 0));
      vecs.push_back(mk(1, 0, 0, 1, 3'b111, 3'b000, RGB3, 3'b000, 0));
      vecs.push_back(mk(1, 0, 0, 1, 3'b111, 3'b110, RGB3, 3'b100, 1));
      vecs.push_back(mk(1, 0, 0, 1, 3'b111, 3'b101, RGB3, 3'b100, 0));
      // Enable masking and blanking
      vecs.push_back(mk(1, 0, 0, 1, 3'b011, 3'b111, RGB3, 3'b010, 0));
      vecs.push_back(mk(1, 0, 0, 0, 3'b011, 3'b111, RGB3, 3'b011, 0));
      vecs.push_back(mk(1, 1, 0, 0, 3'b111, 3'b111, RGB3, 3'b000, 0));
      vecs.push_back(mk(0, 0, 0, 0, 3'b111, 3'b111, RGB3, 3'b000, 0));
      vecs.push_back(mk(1, 0, 0, 1, 3'b101, 3'b110, RGB3, 3'b100, 0));
      // Collision count: new frame, five L1/L2 overlaps, then boundary on L0/L1
      vecs.push_back(mk(1, 0, 1, 0, 3'b111, 3'b001, RGB3, 3'b001, 0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 0, 0, 0, 3'b111, 3'b110, RGB3, 3'b110, 1));
      vecs.push_back(mk(1, 0, 1, 0, 3'b111, 3'b011, RGB3, 3'b011, 0));
      vecs.push_back(mk(1, 0, 0, 0, 3'b111, 3'b011, RGB3, 3'b011, 0));
      // Saturation and boundary on a colliding pixel, then empty frames
      vecs.push_back(mk(1, 0, 1, 0, 3'b111, 3'b000, RGB3, 3'b000, 0));
      for (int i = 0; i < 20; i++)
         vecs.push_back(mk(1, 0, 0, 0, 3'b111, 3'b111, RGB3, 3'b111, 1));
      vecs.push_back(mk(1, 0, 1, 0, 3'b111, 3'b111, RGB3, 3'b111, 1));
      vecs.push_back(mk(0, 0, 1, 0, 3'b111, 3'b111, RGB3, 3'b000, 0));
      vecs.push_back(mk(1, 0, 1, 0, 3'b111, 3'b000, RGB3, 3'b000, 0));
      vecs.push_back(mk(1, 0, 0, 1, 3'b111, 3'b110, RGB3, 3'b100, 1));

      $display("[TB] starting");
      resetDut(idle);

      // Legacy equivalence: every colour combination, OR mode, all covering
      for (int k = 0; k < 512; k++) begin
         k9 = 9'(k);
         step(mk(1, 0, 0, 0, 3'b111, 3'b111, k9, k9[8:6] | k9[5:3] | k9[2:0], 1));
      end

      foreach (vecs[i]) step(vecs[i]);

      // Reset in the middle of a colliding run, released on a valid pixel
      for (int i = 0; i < 3; i++)
         step(mk(1, 0, 0, 0, 3'b111, 3'b110, RGB3, 3'b110, 1));
      resetDut(mk(1, 0, 0, 0, 3'b111, 3'b110, RGB3, 3'b110, 1));
      for (int i = 0; i < 3; i++)
         step(mk(1, 0, 0, 1, 3'b111, 3'b110, RGB3, 3'b100, 1));
      step(mk(1, 0, 1, 0, 3'b111, 3'b000, RGB3, 3'b000, 0));

      // Drain the pipeline
      step(idle);
      step(idle);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
